// File: rtl/sram_pkg.sv
// Shared SRAM definitions: geometry of sky130_sram_2kbyte_1rw1r_32x512_8 and
// the burst-reader FSM state encoding.
package sram_pkg;

   localparam int SRAM_ADDR_W    = 9;
   localparam int SRAM_DATA_W    = 32;
   localparam int BYTES_PER_WORD = SRAM_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      SEND  = 2'd3
   } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one SRAM word and emits it as bytes under valid/ready, flagging the
// final byte so the reader FSM knows when the word is exhausted.
module word_byte_serializer #(
   parameter int DATA_W  = 32,
   parameter bit BYTE_LE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              last_byte
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  lane;
   logic              valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         idx     <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= word;
         idx     <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
         if (idx == LAST_IDX) begin
            valid_q <= 1'b0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   // Lane is the byte position within the word; big-endian order walks it downward.
   always_comb begin
      lane      = BYTE_LE ? idx : (LAST_IDX - idx);
      out_data  = 8'(word_q >> {lane, 3'b000});
      out_valid = valid_q;
      last_byte = valid_q && (idx == LAST_IDX);
   end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst reader on the read-only port 1 of the sky130 32x512 SRAM: one csb1-low
// cycle per word, each captured word streamed out as bytes on valid/ready.
module sram_burst_reader
   import sram_pkg::*;
#(
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int DATA_W  = SRAM_DATA_W,
   parameter bit BYTE_LE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ram_clk1,
   output logic              ram_csb1,
   output logic [ADDR_W-1:0] ram_addr1,
   input  logic [DATA_W-1:0] ram_dout1,
   output logic [1:0]        dbg_state
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   remaining;
   logic              done_q;
   logic              ser_load;
   logic              last_byte;
   logic              hs_last;
   logic              more_words;

   assign ram_clk1   = clk;
   assign hs_last    = out_valid && out_ready && last_byte;
   assign more_words = remaining > (ADDR_W + 1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = SEND;
         SEND:    if (hs_last) state_nxt = more_words ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The SRAM latches addr1 at the edge ending ISSUE; dout1 is valid through WAIT.
   always_comb begin
      ram_csb1  = 1'b1;
      ram_addr1 = '0;
      ser_load  = 1'b0;
      busy      = (state != IDLE);
      done      = done_q;
      dbg_state = state;
      if (state == ISSUE) begin
         ram_csb1  = 1'b0;
         ram_addr1 = cur_addr;
      end
      if (state == WAIT) begin
         ser_load = 1'b1;
      end
   end

   // word_count of zero means the whole array, hence the extra remaining bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr  <= '0;
         remaining <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state == SEND) && hs_last && !more_words;
         if ((state == IDLE) && start) begin
            cur_addr  <= start_addr;
            remaining <= (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                            : {1'b0, word_count};
         end else if ((state == SEND) && hs_last && more_words) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
         end
      end
   end

   word_byte_serializer #(
      .DATA_W  (DATA_W),
      .BYTE_LE (BYTE_LE)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .word      (ram_dout1),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .last_byte (last_byte)
   );

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: behavioural SRAM on port 1, a byte and
// address expectation model built from memory contents, and literal pins.
module tb_sram_burst_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  start_addr = '0;
   logic [8:0]  word_count = '0;
   logic        busy;
   logic        done;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        ram_clk1;
   logic        ram_csb1;
   logic [8:0]  ram_addr1;
   logic [31:0] ram_dout1;
   logic [1:0]  dbg_state;

   logic [31:0] mem [512];

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [8:0] exp_addr_q[$];
   logic [7:0] got_q[$];
   logic [8:0] got_addr_q[$];
   int         bytes_seen = 0;
   int         csb_cnt    = 0;
   bit         chk_en      = 1'b0;
   bit         expect_done = 1'b0;
   bit         prev_stall  = 1'b0;
   logic [7:0] prev_data   = '0;
   bit         rand_ready  = 1'b0;

   logic [7:0] lit1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12, 8'h23, 8'h34, 8'h45};
   logic [7:0] lit2 [8] = '{8'h10, 8'h23, 8'h34, 8'h45, 8'h11, 8'h22, 8'h33, 8'h44};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   sram_burst_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ram_clk1   (ram_clk1),
      .ram_csb1   (ram_csb1),
      .ram_addr1  (ram_addr1),
      .ram_dout1  (ram_dout1),
      .dbg_state  (dbg_state)
   );

   // Read port of the SRAM: address sampled at the edge, data valid next cycle.
   always @(posedge ram_clk1) begin
      if (ram_csb1 === 1'b0) ram_dout1 <= mem[ram_addr1];
   end

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests_run++;
      tests_failed++;
      $display("FAIL %s: event observed but not expected", name);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
         end
         prev_stall = !rst && out_valid && !out_ready;
         prev_data  = out_data;

         if (expect_done) begin
            check("done_pulse", 32'(done), 32'd1);
            check("busy_after_done", 32'(busy), 32'd0);
            expect_done = 1'b0;
         end else begin
            check("no_spurious_done", 32'(done), 32'd0);
         end

         if (!rst && ram_csb1 == 1'b0) begin
            csb_cnt++;
            got_addr_q.push_back(ram_addr1);
            check("csb_no_pending_byte", 32'(out_valid), 32'd0);
            if (exp_addr_q.size() == 0) fail_now("unexpected_read");
            else check("read_addr", 32'(ram_addr1), 32'(exp_addr_q.pop_front()));
         end

         if (!rst && out_valid && out_ready) begin
            bytes_seen++;
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
               fail_now("unexpected_byte");
            end else begin
               check("byte", 32'(out_data), 32'(exp_q.pop_front()));
               if (exp_q.size() == 0) expect_done = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_burst(input int addr, input int cnt);
      int n;
      n = (cnt == 0) ? 512 : cnt;
      for (int i = 0; i < n; i++) begin
         int          a;
         logic [31:0] w;
         a = (addr + i) % 512;
         w = mem[a];
         exp_addr_q.push_back(9'(a));
         for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
   endtask

   task automatic start_burst(input int addr, input int cnt);
      start_addr = 9'(addr);
      word_count = 9'(cnt);
      start      = 1'b1;
      push_burst(addr, cnt);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while ((busy || exp_q.size() != 0) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= budget) fail_now("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      got_q.delete();
      got_addr_q.delete();
      bytes_seen = 0;
      csb_cnt    = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h44332211 + 32'(i) * 32'h01010101;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_csb", 32'(ram_csb1), 32'd1);
      check("rst_addr", 32'(ram_addr1), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // basic two-word burst
      clear_logs();
      start_burst(0, 2);
      check("t1_issue_csb", 32'(ram_csb1), 32'd0);
      check("t1_issue_addr", 32'(ram_addr1), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      wait_idle(100);
      check("t1_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < got_q.size()) check("t1_lit", 32'(got_q[i]), 32'(lit1[i]));
      check("t1_reads", 32'(csb_cnt), 32'd2);

      // address wrap 511 -> 0
      clear_logs();
      start_burst(511, 2);
      wait_idle(100);
      check("t2_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < got_q.size()) check("t2_lit", 32'(got_q[i]), 32'(lit2[i]));
      check("t2_reads", 32'(got_addr_q.size()), 32'd2);
      if (got_addr_q.size() == 2) begin
         check("t2_addr0", 32'(got_addr_q[0]), 32'd511);
         check("t2_addr1", 32'(got_addr_q[1]), 32'd0);
      end

      // random backpressure
      clear_logs();
      rand_ready = 1'b1;
      start_burst(5, 4);
      wait_idle(2000);
      rand_ready = 1'b0;
      check("t3_bytes", 32'(bytes_seen), 32'd16);
      check("t3_reads", 32'(csb_cnt), 32'd4);

      // full array
      clear_logs();
      start_burst(100, 0);
      wait_idle(5000);
      check("t4_bytes", 32'(bytes_seen), 32'd2048);
      check("t4_reads", 32'(csb_cnt), 32'd512);
      if (got_addr_q.size() == 512) begin
         check("t4_first_addr", 32'(got_addr_q[0]), 32'd100);
         check("t4_last_addr", 32'(got_addr_q[511]), 32'd99);
      end

      // start while busy is ignored
      clear_logs();
      start_burst(0, 3);
      repeat (4) begin @(posedge clk); #1; end
      start_addr = 9'd200;
      word_count = 9'd5;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(200);
      check("t5_bytes", 32'(bytes_seen), 32'd12);
      check("t5_reads", 32'(csb_cnt), 32'd3);

      // start in the done cycle
      clear_logs();
      start_burst(10, 2);
      begin
         int c;
         c = 0;
         while (!done && c < 100) begin @(posedge clk); #1; c++; end
         if (c >= 100) fail_now("t6_done_timeout");
      end
      start_burst(20, 1);
      check("t6_issue_csb", 32'(ram_csb1), 32'd0);
      check("t6_issue_addr", 32'(ram_addr1), 32'd20);
      wait_idle(100);
      check("t6_bytes", 32'(bytes_seen), 32'd12);

      // reset in the middle of word 1 of 3
      clear_logs();
      start_burst(0, 3);
      begin
         int c;
         c = 0;
         while (bytes_seen < 5 && c < 100) begin @(posedge clk); #1; c++; end
         if (c >= 100) fail_now("t7_byte_timeout");
      end
      rst = 1'b1;
      exp_q.delete();
      exp_addr_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("t7_valid", 32'(out_valid), 32'd0);
      check("t7_csb", 32'(ram_csb1), 32'd1);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      clear_logs();
      start_burst(30, 2);
      wait_idle(100);
      check("t7_bytes_after", 32'(bytes_seen), 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      fail_now("global_timeout");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
